// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and decode helpers for the RV32I multicycle control unit
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXCT_R, S_EXCT_I,
    S_ALU_WB, S_BQ, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC
  } state_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_R      = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6f
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {EXT_I, EXT_S, EXT_B, EXT_U, EXT_J} ext_op_e;

  typedef enum logic [1:0] {A_PC, A_OLDPC, A_RS1, A_ZERO} alu_src_a_e;

  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_src_b_e;

  typedef enum logic [1:0] {RES_ALUOUT, RES_MEMDATA, RES_ALURESULT} result_src_e;

  typedef enum logic {ADR_PC, ADR_ALUOUT} adr_src_e;

  // Encodings the control unit cannot execute are trapped in S_DECODE
  function automatic logic instr_legal(input opcode_e op, input logic [2:0] f3);
    case (op)
      OP_LOAD:   return !(f3 == 3'd3 || f3 >= 3'd6);
      OP_STORE:  return f3 <= 3'd2;
      OP_BRANCH: return f3 != 3'd2 && f3 != 3'd3;
      OP_R, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic state_t dispatch(input opcode_e op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEM_ADR;
      OP_R:              return S_EXCT_R;
      OP_IMM:            return S_EXCT_I;
      OP_BRANCH:         return S_BQ;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR1;
      OP_LUI:            return S_LUI;
      OP_AUIPC:          return S_AUIPC;
      default:           return S_FETCH;
    endcase
  endfunction

  function automatic ext_op_e decode_ext(input opcode_e op);
    return op == OP_BRANCH ? EXT_B :
           op == OP_JAL    ? EXT_J :
           op == OP_STORE  ? EXT_S :
           (op == OP_LUI || op == OP_AUIPC) ? EXT_U : EXT_I;
  endfunction

  // Branch decision from the flags of rs1 - rs2; carry set means no borrow
  function automatic logic branch_take(input logic [2:0] f3, input logic z, input logic n,
                                       input logic v, input logic c);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n ^ v;
      3'd5:    return !(n ^ v);
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// riscv_alu_decoder: maps funct3/funct7b5 to the ALU operation for R and I types
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_r,
  output alu_op_e    alu_op
);

  // funct7b5 only matters for SUB (R-type) and SRA/SRAI
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'd0: alu_op = (is_r && funct7b5) ? ALU_SUB : ALU_ADD;
      3'd1: alu_op = ALU_SLL;
      3'd2: alu_op = ALU_SLT;
      3'd3: alu_op = ALU_SLTU;
      3'd4: alu_op = ALU_XOR;
      3'd5: alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'd6: alu_op = ALU_OR;
      3'd7: alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_control_fsm.sv
// riscv_control_fsm: multicycle RV32I control unit sequencing the datapath
module riscv_control_fsm
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic        alu_ovf,
  input  logic        alu_carry,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output adr_src_e    adr_src,
  output logic        mem_write,
  output logic        reg_write,
  output alu_src_a_e  alu_src_a,
  output alu_src_b_e  alu_src_b,
  output result_src_e result_src,
  output alu_op_e     alu_op,
  output ext_op_e     ext_op,
  output logic        pc_lsb_clr,
  output logic        illegal_instr,
  output state_t      state_o
);

  state_t  state, next;
  opcode_e op;
  alu_op_e dec_op;
  logic    legal, take, is_r;

  assign op      = opcode_e'(opcode);
  assign legal   = instr_legal(op, funct3);
  assign take    = branch_take(funct3, alu_zero, alu_neg, alu_ovf, alu_carry);
  assign is_r    = state == S_EXCT_R;
  assign state_o = state;

  riscv_alu_decoder u_dec (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_r     (is_r),
    .alu_op   (dec_op)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_FETCH;
    else state <= next;

  // Next state and datapath controls; strobes are forced low while reset is held
  always_comb begin
    next          = S_FETCH;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = ADR_PC;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALU_ADD;
    ext_op        = EXT_I;
    pc_lsb_clr    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b  = B_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        next       = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a     = A_OLDPC;
        alu_src_b     = B_IMM;
        ext_op        = decode_ext(op);
        illegal_instr = !legal;
        next          = legal ? dispatch(op) : S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        ext_op    = op == OP_STORE ? EXT_S : EXT_I;
        next      = op == OP_STORE ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        adr_src = ADR_ALUOUT;
        next    = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
        next      = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXCT_R: begin
        alu_src_a = A_RS1;
        alu_op    = dec_op;
        next      = S_ALU_WB;
      end
      S_EXCT_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = dec_op;
        next      = S_ALU_WB;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BQ: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_SUB;
        pc_write  = take;
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        next      = S_ALU_WB;
      end
      S_JALR1: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        next      = S_JALR2;
      end
      S_JALR2: begin
        alu_src_a  = A_OLDPC;
        alu_src_b  = B_FOUR;
        pc_lsb_clr = 1'b1;
        pc_write   = 1'b1;
        next       = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        ext_op    = EXT_U;
        next      = S_ALU_WB;
      end
      S_AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        ext_op    = EXT_U;
        next      = S_ALU_WB;
      end
      default: next = S_FETCH;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_control_fsm.sv
// tb_riscv_control_fsm: randomized and directed checks of the control unit against an instruction-level model
module tb_riscv_control_fsm;
  import riscv_pkg::*;

  logic clk = 0, rst = 1;
  logic [6:0] opcode = 7'h13;
  logic [2:0] funct3 = 0;
  logic funct7b5 = 0, alu_zero = 0, alu_neg = 0, alu_ovf = 0, alu_carry = 0, mem_ready = 1;
  logic pc_write, ir_write, mem_write, reg_write, pc_lsb_clr, illegal_instr;
  adr_src_e adr_src;
  alu_src_a_e alu_src_a;
  alu_src_b_e alu_src_b;
  result_src_e result_src;
  alu_op_e alu_op;
  ext_op_e ext_op;
  state_t state_o;

  int vectors = 0, errs = 0;
  int n_cyc, n_rw, n_ill, n_lsb, bq_pcw, first_irw;
  state_t seen[$];
  state_t exp_path[$];

  typedef struct {
    int pcw, irw, adr, mw, rw, a, b, res, aop, ext, lsb, ill;
  } exp_t;

  always #5 clk = ~clk;

  riscv_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .ext_op(ext_op), .pc_lsb_clr(pc_lsb_clr),
    .illegal_instr(illegal_instr), .state_o(state_o)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s: got %0d, want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_m(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      7'h03: return !(f3 == 3 || f3 == 6 || f3 == 7);
      7'h23: return f3 <= 2;
      7'h63: return !(f3 == 2 || f3 == 3);
      7'h33, 7'h13, 7'h6f, 7'h67, 7'h37, 7'h17: return 1;
      default: return 0;
    endcase
  endfunction

  // State sequence of one instruction with no stalls
  function automatic void build_path(input logic [6:0] op, input logic [2:0] f3);
    exp_path.delete();
    exp_path.push_back(S_FETCH);
    exp_path.push_back(S_DECODE);
    if (!legal_m(op, f3)) return;
    case (op)
      7'h03: begin exp_path.push_back(S_MEM_ADR); exp_path.push_back(S_MEM_RD); exp_path.push_back(S_MEM_WB); end
      7'h23: begin exp_path.push_back(S_MEM_ADR); exp_path.push_back(S_MEM_WR); end
      7'h33: begin exp_path.push_back(S_EXCT_R); exp_path.push_back(S_ALU_WB); end
      7'h13: begin exp_path.push_back(S_EXCT_I); exp_path.push_back(S_ALU_WB); end
      7'h63: exp_path.push_back(S_BQ);
      7'h6f: begin exp_path.push_back(S_JAL); exp_path.push_back(S_ALU_WB); end
      7'h67: begin exp_path.push_back(S_JALR1); exp_path.push_back(S_JALR2); exp_path.push_back(S_ALU_WB); end
      7'h37: begin exp_path.push_back(S_LUI); exp_path.push_back(S_ALU_WB); end
      default: begin exp_path.push_back(S_AUIPC); exp_path.push_back(S_ALU_WB); end
    endcase
  endfunction

  // Mnemonic table: add/sub sll slt sltu xor srl/sra or and
  function automatic int alu_m(input logic [2:0] f3, input logic f7, input bit r);
    case (f3)
      0: return (r && f7) ? int'(ALU_SUB) : int'(ALU_ADD);
      1: return int'(ALU_SLL);
      2: return int'(ALU_SLT);
      3: return int'(ALU_SLTU);
      4: return int'(ALU_XOR);
      5: return f7 ? int'(ALU_SRA) : int'(ALU_SRL);
      6: return int'(ALU_OR);
      default: return int'(ALU_AND);
    endcase
  endfunction

  function automatic bit take_m(input logic [2:0] f3);
    case (f3)
      0: return alu_zero;
      1: return !alu_zero;
      4: return alu_neg != alu_ovf;
      5: return alu_neg == alu_ovf;
      6: return !alu_carry;
      7: return alu_carry;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(input state_t s, input logic [6:0] op, input logic [2:0] f3, input logic f7);
    exp_t e;
    e = '{default: 0};
    e.aop = int'(ALU_ADD);
    e.ext = int'(EXT_I);
    case (s)
      S_FETCH:   begin e.b = 2; e.res = 2; e.irw = int'(mem_ready); e.pcw = int'(mem_ready); end
      S_DECODE:  begin
        e.a = 1; e.b = 1; e.ill = legal_m(op, f3) ? 0 : 1;
        e.ext = op == 7'h63 ? int'(EXT_B) : op == 7'h6f ? int'(EXT_J) : op == 7'h23 ? int'(EXT_S) :
                (op == 7'h37 || op == 7'h17) ? int'(EXT_U) : int'(EXT_I);
      end
      S_MEM_ADR: begin e.a = 2; e.b = 1; e.ext = op == 7'h23 ? int'(EXT_S) : int'(EXT_I); end
      S_MEM_RD:  e.adr = 1;
      S_MEM_WB:  begin e.res = 1; e.rw = 1; end
      S_MEM_WR:  begin e.adr = 1; e.mw = 1; end
      S_EXCT_R:  begin e.a = 2; e.aop = alu_m(f3, f7, 1); end
      S_EXCT_I:  begin e.a = 2; e.b = 1; e.aop = alu_m(f3, f7, 0); end
      S_ALU_WB:  e.rw = 1;
      S_BQ:      begin e.a = 2; e.aop = int'(ALU_SUB); e.pcw = int'(take_m(f3)); end
      S_JAL:     begin e.a = 1; e.b = 2; e.pcw = 1; end
      S_JALR1:   begin e.a = 2; e.b = 1; end
      S_JALR2:   begin e.a = 1; e.b = 2; e.lsb = 1; e.pcw = 1; end
      S_LUI:     begin e.a = 3; e.b = 1; e.ext = int'(EXT_U); end
      S_AUIPC:   begin e.a = 1; e.b = 1; e.ext = int'(EXT_U); end
      default: ;
    endcase
    return e;
  endfunction

  // Runs one instruction from S_FETCH, checking every cycle; starts and ends 1 time unit after a rising edge
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input bit rnd, input int stalls, input logic [3:0] flg);
    int i = 0, wait_n = 0;
    exp_t e;
    state_t s;
    build_path(op, f3);
    opcode = op; funct3 = f3; funct7b5 = f7;
    n_cyc = 0; n_rw = 0; n_ill = 0; n_lsb = 0; bq_pcw = -1; first_irw = -1;
    seen.delete();
    while (i < exp_path.size()) begin
      s = exp_path[i];
      if (rnd) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        {alu_zero, alu_neg, alu_ovf, alu_carry} = 4'($urandom);
      end else begin
        mem_ready = (s == S_MEM_RD || s == S_MEM_WR) ? (wait_n >= stalls) : 1'b1;
        {alu_zero, alu_neg, alu_ovf, alu_carry} = flg;
      end
      @(negedge clk);
      e = model(s, op, f3, f7);
      chk("state", int'(state_o), int'(s));
      chk("pc_write", int'(pc_write), e.pcw);
      chk("ir_write", int'(ir_write), e.irw);
      chk("adr_src", int'(adr_src), e.adr);
      chk("mem_write", int'(mem_write), e.mw);
      chk("reg_write", int'(reg_write), e.rw);
      chk("alu_src_a", int'(alu_src_a), e.a);
      chk("alu_src_b", int'(alu_src_b), e.b);
      chk("result_src", int'(result_src), e.res);
      chk("alu_op", int'(alu_op), e.aop);
      chk("ext_op", int'(ext_op), e.ext);
      chk("pc_lsb_clr", int'(pc_lsb_clr), e.lsb);
      chk("illegal_instr", int'(illegal_instr), e.ill);
      seen.push_back(state_o);
      n_rw += int'(reg_write);
      n_ill += int'(illegal_instr);
      n_lsb += int'(pc_lsb_clr);
      if (s == S_BQ) bq_pcw = int'(pc_write);
      if (n_cyc == 0) first_irw = int'(ir_write);
      n_cyc++;
      if ((s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR) && !mem_ready) wait_n++;
      else begin i++; wait_n = 0; end
      @(posedge clk);
      #1;
      if (n_cyc >= 200) begin
        chk("cycle_budget", n_cyc, -1);
        break;
      end
    end
  endtask

  initial begin
    logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6f};
    logic [6:0] rop;
    @(negedge clk);
    chk("rst_state", int'(state_o), int'(S_FETCH));
    chk("rst_ir_write", int'(ir_write), 0);
    chk("rst_pc_write", int'(pc_write), 0);
    @(posedge clk);
    #1;
    rst = 0;
    opcode = 7'h23; funct3 = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 0;
    @(negedge clk);
    chk("sw_state", int'(state_o), int'(S_MEM_WR));
    chk("sw_mem_write", int'(mem_write), 1);
    #2;
    rst = 1;
    mem_ready = 1;
    #1;
    chk("abort_state", int'(state_o), int'(S_FETCH));
    repeat (3) begin
      @(negedge clk);
      chk("hold_state", int'(state_o), int'(S_FETCH));
      chk("hold_mem_write", int'(mem_write), 0);
      chk("hold_ir_write", int'(ir_write), 0);
      chk("hold_reg_write", int'(reg_write), 0);
    end
    @(posedge clk);
    #1;
    rst = 0;
    run_instr(7'h33, 3'd0, 1'b0, 0, 0, 4'b0000);
    chk("post_rst_ir_write", first_irw, 1);
    chk("add_cycles", n_cyc, 4);
    chk("add_reg_writes", n_rw, 1);
    chk("add_exec_state", int'(seen[2]), int'(S_EXCT_R));
    run_instr(7'h03, 3'd2, 1'b0, 0, 2, 4'b0000);
    chk("lw_cycles", n_cyc, 7);
    chk("lw_reg_writes", n_rw, 1);
    chk("lw_last_state", int'(seen[6]), int'(S_MEM_WB));
    run_instr(7'h63, 3'd4, 1'b0, 0, 0, 4'b0100);
    chk("blt_taken", bq_pcw, 1);
    chk("blt_cycles", n_cyc, 3);
    run_instr(7'h63, 3'd4, 1'b0, 0, 0, 4'b0110);
    chk("blt_not_taken", bq_pcw, 0);
    run_instr(7'h67, 3'd0, 1'b0, 0, 0, 4'b0000);
    chk("jalr_cycles", n_cyc, 5);
    chk("jalr_lsb_clr", n_lsb, 1);
    chk("jalr_state3", int'(seen[2]), int'(S_JALR1));
    chk("jalr_state4", int'(seen[3]), int'(S_JALR2));
    run_instr(7'h7f, 3'd0, 1'b0, 0, 0, 4'b0000);
    chk("ill_op_pulse", n_ill, 1);
    chk("ill_op_cycles", n_cyc, 2);
    run_instr(7'h03, 3'd7, 1'b0, 0, 0, 4'b0000);
    chk("ill_ld_pulse", n_ill, 1);
    chk("ill_ld_reg_writes", n_rw, 0);
    run_instr(7'h23, 3'd2, 1'b0, 0, 1, 4'b0000);
    chk("sw_cycles", n_cyc, 5);
    run_instr(7'h33, 3'd0, 1'b1, 0, 0, 4'b0000);
    run_instr(7'h13, 3'd0, 1'b1, 0, 0, 4'b0000);
    run_instr(7'h13, 3'd5, 1'b1, 0, 0, 4'b0000);
    for (int n = 0; n < 400; n++) begin
      rop = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      run_instr(rop, 3'($urandom), 1'($urandom), 1, 0, 4'b0000);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/riscv_control_fsm.md
Name: riscv_control_fsm

Overview:
- Multicycle control unit for the RV32I core; consumes `state_t`, `opcode_e`, `alu_op_e` and `ext_op_e` from `riscv_pkg`.
- Sequences every instruction through the `state_t` states.
- Drives datapath mux selects, write enables, ALU op and immediate-extension op.
- Evaluates branch conditions from ALU flags.
- Sits between the instruction register and the datapath/memory.

Parameters:
- None. All widths come from `riscv_pkg`.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `alu_zero` in 1: ALU result == 0.
- `alu_neg` in 1: ALU result[31].
- `alu_ovf` in 1: signed overflow of the ALU add/sub.
- `alu_carry` in 1: carry-out; for SUB, 1 means no borrow.
- `mem_ready` in 1: memory completes the access this cycle.
- `pc_write` out 1: PC register enable.
- `ir_write` out 1: instruction register and old-PC register enable.
- `adr_src` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_write` out 1: data-memory write strobe.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: 0 PC, 1 OLDPC, 2 RS1, 3 ZERO.
- `alu_src_b` out 2: 0 RS2, 1 IMM, 2 FOUR.
- `result_src` out 2: 0 ALUOUT, 1 MEMDATA, 2 ALURESULT.
- `alu_op` out 4 (`alu_op_e`): ALU operation.
- `ext_op` out 3 (`ext_op_e`): immediate format.
- `pc_lsb_clr` out 1: clear bit 0 of the Result bus (JALR).
- `illegal_instr` out 1: one-cycle pulse in S_DECODE on an unsupported encoding.
- `state_o` out 4 (`state_t`): current state, for debug.

Behaviour:
- Reset:
  - Single clock `clk`; reset `rst` is asynchronous and active-high.
  - While `rst`=1: state = S_FETCH, and `pc_write`, `ir_write`, `mem_write`, `reg_write`, `illegal_instr` are all 0.
  - Asserting `rst` mid-instruction aborts it immediately with no further writes.
  - First fetch occurs in the first cycle after deassertion.
- Output style:
  - Outputs are combinational from state plus inputs.
  - Write strobes are gated by `mem_ready` where noted.
  - Defaults: all enables 0, `alu_op`=ADD, `ext_op`=`EXT_I`, selects 0.
- S_FETCH:
  - `adr_src`=0, A=PC, B=FOUR, ADD, `result_src`=ALURESULT.
  - `ir_write` and `pc_write` = `mem_ready`.
  - Stay in S_FETCH while `mem_ready`=0; go to S_DECODE when 1.
- S_DECODE:
  - A=OLDPC, B=IMM, ADD; computes the branch/JAL target into ALUOut.
  - `ext_op` by opcode: B→`EXT_B`, J→`EXT_J`, S→`EXT_S`, LUI/AUIPC→`EXT_U`, else `EXT_I`.
  - Next state: L/S→S_MEM_ADR; R→S_EXCT_R; I→S_EXCT_I; B→S_BQ; JAL→S_JAL; JALR→S_JALR1; LUI→S_LUI; AUIPC→S_AUIPC.
  - Any other opcode, load funct3 ∈ {3,6,7}, store funct3 > 2, or branch funct3 ∈ {2,3}: pulse `illegal_instr` and go to S_FETCH with no writes.
- S_MEM_ADR: A=RS1, B=IMM, ADD, `ext_op` `EXT_I` or `EXT_S`. Next is S_MEM_RD for a load, S_MEM_WR for a store.
- S_MEM_RD: `adr_src`=1; hold until `mem_ready`, then go to S_MEM_WB.
- S_MEM_WB: `result_src`=MEMDATA, `reg_write`=1; go to S_FETCH. Byte/half extraction is done by the datapath, not here.
- S_MEM_WR: `adr_src`=1, `mem_write`=1 every cycle held; hold until `mem_ready`, then go to S_FETCH.
- S_EXCT_R: A=RS1, B=RS2, `alu_op` from the decoder; go to S_ALU_WB.
- S_EXCT_I: A=RS1, B=IMM, `alu_op` from the decoder; `funct7b5` is honoured only for funct3=5 (SRAI). Go to S_ALU_WB.
- S_ALU_WB: `result_src`=ALUOUT, `reg_write`=1; go to S_FETCH.
- S_BQ:
  - A=RS1, B=RS2, SUB, `result_src`=ALUOUT (target).
  - `pc_write` = take, where:
    - BEQ: `zero`; BNE: `!zero`.
    - BLT: `neg^ovf`; BGE: `!(neg^ovf)`.
    - BLTU: `!carry`; BGEU: `carry`.
  - Go to S_FETCH.
- S_JAL: A=OLDPC, B=FOUR, ADD, `result_src`=ALUOUT, `pc_write`=1; go to S_ALU_WB, which writes PC+4 to rd.
- S_JALR1: A=RS1, B=IMM, ADD; go to S_JALR2.
- S_JALR2: A=OLDPC, B=FOUR, `result_src`=ALUOUT, `pc_lsb_clr`=1, `pc_write`=1; go to S_ALU_WB.
- S_LUI: A=ZERO, B=IMM, `EXT_U`; go to S_ALU_WB.
- S_AUIPC: A=OLDPC, B=IMM, `EXT_U`; go to S_ALU_WB.
- CPI: R/I/LUI/AUIPC 4, load 5, store 4, branch 3, JAL 4, JALR 5 (with `mem_ready` tied 1). Each stall cycle adds 1.
- Unreachable state encodings go to S_FETCH.

Decomposition:
- Add to `riscv_pkg`: enums `alu_src_a_e`, `alu_src_b_e`, `result_src_e`, `adr_src_e` with the encodings above.
- Sub-module `riscv_alu_decoder` (combinational): inputs `funct3`, `funct7b5`, `is_r`; outputs `alu_op_e`. R-type funct3=0 with `funct7b5`=1 selects SUB.

Test Plan:
- Reset held 3 cycles mid-S_MEM_WR → state S_FETCH, `mem_write`=0 during reset; after release `ir_write`=1 in the first cycle with `mem_ready`=1.
- `add` (0x33, f3 0), `mem_ready`=1 → states FETCH, DECODE, EXCT_R, ALU_WB; `alu_op`=ADD; `reg_write` high only in cycle 4.
- `lw` with `mem_ready` low 2 cycles in S_MEM_RD → 7 cycles total; `reg_write` once, in S_MEM_WB.
- `blt`, f3=4, `neg`=1 `ovf`=0 → `pc_write`=1 in S_BQ; with `neg`=1 `ovf`=1 → `pc_write`=0.
- `jalr` → FETCH, DECODE, JALR1, JALR2 (`pc_lsb_clr`=1, `pc_write`=1), ALU_WB.
- opcode 0x7F, then load with f3=7 → `illegal_instr` pulses 1 cycle in S_DECODE, next state S_FETCH, no write enables asserted.
